// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready load/store front end over a word-organised array,
// with RISC-V sub-word access, fault reporting, fixed access latency and a clear sweep.
module data_memory_ctrl #(
   parameter int MEM_DEPTH      = 16384,
   parameter int LATENCY        = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        init_done
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

   state_t        state, state_next;
   logic [AW-1:0] clr_cnt, clr_cnt_next;
   logic [3:0]    lat_cnt, lat_cnt_next;
   logic          valid_next, error_next, init_next, latch;
   logic [31:0]   rdata_next;

   logic [31:0]   addr_q, wdata_q;
   logic          write_q;
   logic [2:0]    funct3_q;

   logic [31:0]   mem [MEM_DEPTH];

   logic [31:0]   ev_addr, ev_wdata, ev_old, ev_load, ev_wword;
   logic          ev_write, ev_err, ev_oor, commit;
   logic [2:0]    ev_funct3;
   logic [AW-1:0] ev_word;
   logic [3:0]    ev_be;
   logic [7:0]    ev_byte;
   logic [15:0]   ev_half;

   logic          mem_we;
   logic [AW-1:0] mem_idx;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wd;

   // With LATENCY==1 the commit edge is the accept edge, so evaluate the live request fields.
   always_comb begin
      ev_addr   = (state == IDLE) ? req_addr   : addr_q;
      ev_wdata  = (state == IDLE) ? req_wdata  : wdata_q;
      ev_write  = (state == IDLE) ? req_write  : write_q;
      ev_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
      ev_word   = ev_addr[AW+1:2];
      ev_old    = mem[ev_word];
      ev_oor    = (ev_addr[31:2] >= 30'(MEM_DEPTH));
      ev_byte   = ev_old[8*ev_addr[1:0] +: 8];
      ev_half   = ev_addr[1] ? ev_old[31:16] : ev_old[15:0];
      ev_load   = 32'd0;
      ev_be     = 4'd0;
      ev_wword  = 32'd0;
      ev_err    = ev_oor;
      case (ev_funct3)
         3'b000: begin
            ev_load  = {{24{ev_byte[7]}}, ev_byte};
            ev_be    = 4'b0001 << ev_addr[1:0];
            ev_wword = {4{ev_wdata[7:0]}};
         end
         3'b001: begin
            ev_load  = {{16{ev_half[15]}}, ev_half};
            ev_be    = ev_addr[1] ? 4'b1100 : 4'b0011;
            ev_wword = {2{ev_wdata[15:0]}};
            ev_err   = ev_err | ev_addr[0];
         end
         3'b010: begin
            ev_load  = ev_old;
            ev_be    = 4'b1111;
            ev_wword = ev_wdata;
            ev_err   = ev_err | (ev_addr[1:0] != 2'b00);
         end
         3'b100: begin
            ev_load = {24'd0, ev_byte};
            ev_err  = ev_err | ev_write;
         end
         3'b101: begin
            ev_load = {16'd0, ev_half};
            ev_err  = ev_err | ev_write | ev_addr[0];
         end
         default: ev_err = 1'b1;
      endcase
   end

   // Next-state logic, handshake outputs and the registered response values.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      lat_cnt_next = lat_cnt;
      valid_next   = resp_valid;
      rdata_next   = resp_rdata;
      error_next   = resp_error;
      init_next    = init_done;
      latch        = 1'b0;
      commit       = 1'b0;
      req_ready    = (state == IDLE);
      case (state)
         INIT: begin
            if (!CLEAR_ON_RESET || clr_cnt == AW'(MEM_DEPTH - 1)) begin
               state_next = IDLE;
               init_next  = 1'b1;
            end else begin
               clr_cnt_next = clr_cnt + 1'b1;
            end
         end
         IDLE: begin
            if (req_valid) begin
               latch        = 1'b1;
               lat_cnt_next = WAIT_LOAD;
               if (LATENCY == 1) begin
                  state_next = RESP;
                  commit     = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (lat_cnt == 4'd0) begin
               state_next = RESP;
               commit     = 1'b1;
            end else begin
               lat_cnt_next = lat_cnt - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
               valid_next = 1'b0;
               rdata_next = 32'd0;
               error_next = 1'b0;
            end
         end
         default: state_next = INIT;
      endcase
      if (commit) begin
         valid_next = 1'b1;
         error_next = ev_err;
         rdata_next = (ev_err || ev_write) ? 32'd0 : ev_load;
      end
   end

   // The array has one write port shared by the clear sweep and committed stores.
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = '0;
      mem_be  = 4'd0;
      mem_wd  = 32'd0;
      if (state == INIT && CLEAR_ON_RESET) begin
         mem_we  = 1'b1;
         mem_idx = clr_cnt;
         mem_be  = 4'b1111;
      end else if (commit && ev_write && !ev_err) begin
         mem_we  = 1'b1;
         mem_idx = ev_word;
         mem_be  = ev_be;
         mem_wd  = ev_wword;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= INIT;
         clr_cnt    <= '0;
         lat_cnt    <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_error <= 1'b0;
         init_done  <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         write_q    <= 1'b0;
         funct3_q   <= 3'd0;
      end else begin
         state      <= state_next;
         clr_cnt    <= clr_cnt_next;
         lat_cnt    <= lat_cnt_next;
         resp_valid <= valid_next;
         resp_rdata <= rdata_next;
         resp_error <= error_next;
         init_done  <= init_next;
         if (latch) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            funct3_q <= req_funct3;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: a byte-level reference model predicts every
// response, and a monitor compares each response handshake against the expected queue.
module tb_data_memory_ctrl;

   localparam int DEPTH = 16;
   localparam int LAT   = 3;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'd0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        init_done;

   int          n_cmp = 0;
   int          n_bad = 0;
   resp_t       exp_q[$];
   logic [31:0] model_mem [DEPTH];

   data_memory_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_funct3(req_funct3), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Reference model works on byte offsets and sizes rather than lanes and enables.
   task automatic model_access(input bit w, input logic [2:0] f3, input int unsigned a,
                               input logic [31:0] wd, output resp_t r);
      int unsigned size, off;
      logic [31:0] word;
      longint      v;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off  = a % 4;
      r.rdata = 32'd0;
      r.error = (a / 4 >= DEPTH) || (f3 == 3'd3) || (f3 >= 3'd6) || (w && f3 >= 3'd4) || (a % size != 0);
      if (!r.error) begin
         word = model_mem[a / 4];
         if (w) begin
            for (int i = 0; i < int'(size); i++) word[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
            model_mem[a / 4] = word;
         end else begin
            v = longint'((word >> (8*off)) & 32'hFFFF_FFFF) & ((64'd1 << (8*size)) - 1);
            if (!f3[2] && size < 4 && v >= longint'(64'd1 << (8*size - 1)))
               v = v - longint'(64'd1 << (8*size));
            r.rdata = v[31:0];
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      resp_t e;
      #1;
      if (reset && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_resp: got rdata 0x%08h, expected no response", resp_rdata);
         end else begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_error", {31'd0, resp_error}, {31'd0, e.error});
         end
      end
   end

   task automatic wait_init();
      int n;
      n = 0;
      while (!init_done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("init_cycles", n, DEPTH);
      check("ready_after_init", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic applyStimulus(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input bit hold);
      resp_t       e;
      int          n;
      logic [31:0] held;
      model_access(w, f3, a, wd, e);
      exp_q.push_back(e);
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", {31'd0, req_ready}, 32'd1);
      resp_ready = !hold;
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = $urandom;
      n = 1;
      while (!resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, LAT);
      if (hold) begin
         held = resp_rdata;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_write  = 1'($urandom_range(0, 1));
            req_funct3 = 3'd2;
            req_addr   = 32'($urandom_range(0, DEPTH - 1) * 4);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, held);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
         end
         @(negedge clk);
         req_valid  = 1'b0;
         resp_ready = 1'b1;
      end
      n = 0;
      while (resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("resp_released", {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int n;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      #23;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_error", {31'd0, resp_error}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      wait_init();

      applyStimulus(1'b0, 3'b010, 32'h3C, 32'd0, 1'b0);
      applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);

      applyStimulus(1'b1, 3'b000, 32'h11, 32'h55, 1'b0);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b000, 32'h13, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b100, 32'h13, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b001, 32'h12, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b101, 32'h10, 32'd0, 1'b0);

      applyStimulus(1'b0, 3'b010, 32'h12, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b001, 32'h11, 32'd0, 1'b0);
      applyStimulus(1'b1, 3'b001, 32'h13, 32'hFFFF, 1'b0);
      applyStimulus(1'b0, 3'b011, 32'h10, 32'd0, 1'b0);
      applyStimulus(1'b1, 3'b100, 32'h10, 32'hAA, 1'b0);
      applyStimulus(1'b0, 3'b010, 32'(DEPTH * 4), 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);

      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("single_resp", 32'(exp_q.size()), 32'd0);

      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       32'($urandom_range(0, DEPTH * 4 + 7)), $urandom, 1'b0);
      end

      // Store aborted by reset before its commit edge; the sweep then zeroes everything.
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_no_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_rst_valid", {31'd0, resp_valid}, 32'd0);
      check("abort_rst_init", {31'd0, init_done}, 32'd0);
      check("abort_rst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      wait_init();
      applyStimulus(1'b0, 3'b010, 32'h20, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
